// File: rtl/pio_irq_pkg.sv
// Shared constants and helpers for the debounced PIO interrupt block.
package pio_irq_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGE  = 2'd2;
  localparam logic [1:0] ADDR_EVCNT = 2'd3;

  // Edge selection for capture
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Event counter width
  localparam int unsigned EVCNT_W = 16;

  // Number of set bits in a 32-bit word
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: 2-flop synchroniser, debounce counter, accepted level
// and qualified edge event.
module pio_debounce_ch
  import pio_irq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_MODE       = EDGE_RISE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable,
  output logic evt
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ = sync2 ^ stable;
  // Counter reaching DEBOUNCE_CYCLES on this edge means the new level is taken now.
  assign accept = differ && (cnt == CNT_LAST);

  // Two-stage synchroniser for the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Count consecutive cycles of disagreement; accept the level once long enough
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (!differ) begin
      cnt <= '0;
    end else if (accept) begin
      cnt    <= '0;
      stable <= sync2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Qualify the level change by the selected edge direction
  always_comb begin
    case (EDGE_MODE)
      EDGE_RISE: evt = accept & sync2;
      EDGE_FALL: evt = accept & ~sync2;
      default:   evt = accept;
    endcase
  end

endmodule

// File: rtl/pio_irq_debounce.sv
// Debounced PIO inputs with edge capture, event counter and level IRQ
// behind a 4-word Avalon-MM slave.
module pio_irq_debounce
  import pio_irq_pkg::*;
#(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_MODE       = EDGE_RISE,
  parameter logic [WIDTH-1:0] INVERT          = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       avs_address,
  input  logic             avs_chipselect,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam int unsigned SUM_W = EVCNT_W + 1;

  logic [WIDTH-1:0]   sync_in;
  logic [WIDTH-1:0]   stable;
  logic [WIDTH-1:0]   events;
  logic [WIDTH-1:0]   edge_capture;
  logic [WIDTH-1:0]   irq_mask;
  logic [WIDTH-1:0]   capture_clr;
  logic [EVCNT_W-1:0] event_count;
  logic [EVCNT_W-1:0] count_base;
  logic [EVCNT_W-1:0] count_next;
  logic [SUM_W-1:0]   count_sum;
  logic [31:0]        events_ext;
  logic [31:0]        read_mux;
  logic               wr_en;
  logic               rd_en;
  logic               unused_wdata;

  assign sync_in      = in_port ^ INVERT;
  assign unused_wdata = ^avs_writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pio_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .EDGE_MODE       (EDGE_MODE)
    ) u_ch (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .din    (sync_in[i]),
      .stable (stable[i]),
      .evt    (events[i])
    );
  end

  // Bus decode, event counting with saturation, read mux
  always_comb begin
    wr_en       = avs_chipselect & avs_write;
    rd_en       = avs_chipselect & avs_read;
    capture_clr = (wr_en && avs_address == ADDR_EDGE) ? avs_writedata[WIDTH-1:0] : '0;

    events_ext              = '0;
    events_ext[WIDTH-1:0]   = events;
    // A clear in the same cycle as new events loads the new events, not zero.
    count_base = (wr_en && avs_address == ADDR_EVCNT) ? '0 : event_count;
    count_sum  = SUM_W'(count_base) + SUM_W'(popcount32(events_ext));
    count_next = count_sum[EVCNT_W] ? '1 : count_sum[EVCNT_W-1:0];

    read_mux = '0;
    case (avs_address)
      ADDR_DATA:  read_mux[WIDTH-1:0]   = stable;
      ADDR_MASK:  read_mux[WIDTH-1:0]   = irq_mask;
      ADDR_EDGE:  read_mux[WIDTH-1:0]   = edge_capture;
      ADDR_EVCNT: read_mux[EVCNT_W-1:0] = event_count;
      default:    read_mux              = '0;
    endcase
  end

  // Register file: mask, sticky capture (set wins over clear), event counter
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      event_count  <= '0;
    end else begin
      if (wr_en && avs_address == ADDR_MASK) begin
        irq_mask <= avs_writedata[WIDTH-1:0];
      end
      edge_capture <= (edge_capture & ~capture_clr) | events;
      event_count  <= count_next;
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else if (rd_en) begin
      avs_readdata <= read_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: doc/pio_irq_debounce.md
Name: pio_irq_debounce

Overview:
- Parametrised successor to the plain button/switch PIO inputs on the Nios II system. WIDTH input channels, each with a 2-flop synchroniser, a per-channel debounce counter and programmable edge detection.
- Provides interrupt-masked edge capture and a saturating event counter behind a 4-word Avalon-MM slave.
- Drives one level-sensitive IRQ line to the Nios II interrupt controller.

Parameters:
- WIDTH, 4, number of input channels (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable clk_clk cycles required before a level is accepted (>=1). 50000 = 1 ms at 50 MHz.
- EDGE_MODE, 0, edge that sets capture: 0 rising, 1 falling, 2 any.
- INVERT, 0, WIDTH-bit mask. Channel bits set are inverted before the synchroniser (active-low keys).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- in_port  in  WIDTH  raw asynchronous button/switch inputs.
- avs_address  in  2  word address.
- avs_chipselect  in  1  slave select.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, read latency 1.
- irq  out  1  interrupt request, level.

Behaviour:
- Reset (async assert, sync-released by system): all synchroniser flops, stable levels, counters, edge_capture, irq_mask, event_count and avs_readdata go to 0; irq = 0. With INVERT set for idle-high keys, the post-inversion idle level is 0, so no edge fires after reset.
- Synchroniser: s = INVERT ^ in_port; two flops per channel; sync2 is the debounced source.
- Debounce, per channel, 16-bit-capable counter sized $clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == stable, counter clears.
  - Otherwise counter increments. On the edge where the counter would reach DEBOUNCE_CYCLES, stable <= sync2 and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles resets the count; stable does not change.
- Latency: a clean in_port transition changes stable exactly 2+DEBOUNCE_CYCLES rising edges later. edge_capture and irq update on the same edge.
- Edge detect: event = (stable_next != stable) qualified by EDGE_MODE (rising: stable_next=1; falling: stable_next=0; any).
- Registers (avs_address):
  - 0 DATA RO: {0, stable}.
  - 1 IRQ_MASK RW: WIDTH bits.
  - 2 EDGE_CAPTURE R/W1C: sticky per-channel event bits. A write clears the bits where writedata=1.
  - 3 EVENT_COUNT: bits[15:0] count channel-events, +popcount of events per cycle, saturating at 0xFFFF. Any write clears it to 0.
- Unused readdata bits read 0. Writes to DATA are ignored. Accesses without chipselect are ignored.
- Read: avs_readdata is registered on the edge where chipselect&read, valid the following cycle. It holds its value otherwise.
- Simultaneous W1C clear and new event on the same bit in the same cycle: set wins; the bit stays 1.
- Simultaneous EVENT_COUNT clear and new events: counter loads popcount(events), not 0.
- Saturation: at 0xFFFF further events are dropped from the count; edge_capture is still set.
- irq = |(edge_capture & irq_mask), derived from flops only, no combinational path from bus inputs.
  - Masking a pending bit drops irq the next cycle.
  - Unmasking a pending bit raises irq the next cycle.
- Reset mid-debounce discards the partial count; reset mid-read returns readdata 0.

Decomposition:
- Package pio_irq_pkg:
  - register address constants ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2, ADDR_EVCNT=3.
  - EDGE_RISE/EDGE_FALL/EDGE_ANY constants.
  - EVCNT_W=16.
- Sub-module pio_debounce_ch (one channel: synchroniser, counter, stable, event output), generated WIDTH times.
- Top level holds the register file, popcount/saturation and the Avalon slave.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_MODE=0, INVERT=4'b0001):
- Reset then idle, in_port=4'b0001 -> DATA reads 0, EDGE_CAPTURE 0, irq 0 for 100 cycles.
- in_port[1] 0->1 held, IRQ_MASK=4'b0010 -> exactly 6 edges later DATA=4'b0010, EDGE_CAPTURE=4'b0010, irq=1, EVENT_COUNT=1.
- in_port[2] pulses high for 3 cycles then low -> DATA, EDGE_CAPTURE and EVENT_COUNT unchanged; irq unchanged.
- Write EDGE_CAPTURE=4'b0010 on the same cycle channel 1 sees a new rising event (after a fall/rise) -> bit 1 remains 1, irq stays 1. Then a plain W1C -> bit clears, irq 0 next cycle.
- Preload 0xFFFE events, then raise channels 1 and 2 simultaneously -> EVENT_COUNT=0xFFFF and stays there on further events. Write addr 3 -> reads 0.
- Assert reset_reset_n=0 mid-debounce (counter=2) -> all outputs 0 asynchronously. After release, the still-high input needs a full 6 cycles before DATA reflects it.
